// File: rtl/dtcm.sv
// Data tightly-coupled memory: single-port word SRAM behind a valid/ready
// request channel with a one-cycle response pulse. Byte/half/word access
// with sign/zero extension and a fixed number of wait states per access.
module dtcm #(
  parameter int DEPTH = 4096,
  parameter int WAIT  = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_v,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_v,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  typedef struct packed {
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  state_t            state, state_nxt;
  logic [3:0]        wait_cnt, wait_nxt;
  req_t              req_q, cur;
  logic              accept, commit;
  logic [1:0]        off;
  logic              bad_f3, misal, oor, st_bad, err_c;
  logic [3:0]        be;
  logic [3:0][7:0]   wd;
  logic [AW-1:0]     idx;
  logic [3:0][7:0]   mem [DEPTH];
  logic [31:0]       rd_q;
  logic              p_err, p_we;
  logic [2:0]        p_f3;
  logic [1:0]        p_off;
  logic [7:0]        lane8;
  logic [15:0]       lane16;
  logic [31:0]       ld_ext;

  assign req_ready = (state != S_WAIT);
  // Gate on reset so nothing is committed while reset is held.
  assign accept    = req_v & req_ready & reset_n;

  // With WAIT=0 the access commits on the accept edge straight from the
  // inputs; otherwise it commits from the latched copy when the wait expires.
  assign cur    = (state == S_WAIT) ? req_q
                                    : {req_we, req_funct3, req_addr, req_wdata};
  assign commit = (state == S_WAIT) ? (wait_cnt == 4'd0) : (accept && WAIT == 0);

  assign off = cur.addr[1:0];
  assign idx = cur.addr[AW+1:2];

  // Decode access legality and byte lanes for the committing access.
  always_comb begin
    bad_f3 = 1'b0;
    misal  = 1'b0;
    be     = 4'b1111;
    wd     = cur.wdata;
    case (cur.funct3)
      3'b000, 3'b100: begin
        be = 4'b0001 << off;
        wd = {4{cur.wdata[7:0]}};
      end
      3'b001, 3'b101: begin
        misal = cur.addr[0];
        be    = 4'b0011 << off;
        wd    = {2{cur.wdata[15:0]}};
      end
      3'b010: misal = (off != 2'b00);
      default: bad_f3 = 1'b1;
    endcase
    oor    = (cur.addr >= 32'(DEPTH * 4));
    st_bad = cur.we & cur.funct3[2];
    err_c  = bad_f3 | misal | oor | st_bad;
  end

  // SRAM: masked write and read sample share the commit edge; not reset.
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int b = 0; b < 4; b++)
        if (cur.we && !err_c && be[b]) mem[idx][b] <= wd[b];
      rd_q <= mem[idx];
    end
  end

  // State register, wait counter and request latch.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      wait_cnt <= 4'd0;
      req_q    <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      if (accept) req_q <= {req_we, req_funct3, req_addr, req_wdata};
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    case (state)
      S_IDLE, S_RESP: begin
        if (accept) begin
          if (WAIT == 0) state_nxt = S_RESP;
          else begin
            state_nxt = S_WAIT;
            wait_nxt  = 4'(WAIT - 1);
          end
        end else state_nxt = S_IDLE;
      end
      S_WAIT: begin
        if (wait_cnt == 4'd0) state_nxt = S_RESP;
        else wait_nxt = wait_cnt - 4'd1;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Capture what the response stage needs to format the read word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p_err <= 1'b0;
      p_we  <= 1'b0;
      p_f3  <= 3'b0;
      p_off <= 2'b0;
    end else if (commit) begin
      p_err <= err_c;
      p_we  <= cur.we;
      p_f3  <= cur.funct3;
      p_off <= off;
    end
  end

  // Lane select and extension of the sampled word.
  always_comb begin
    lane8  = rd_q[8*p_off +: 8];
    lane16 = p_off[1] ? rd_q[31:16] : rd_q[15:0];
    case (p_f3)
      3'b000:  ld_ext = {{24{lane8[7]}}, lane8};
      3'b001:  ld_ext = {{16{lane16[15]}}, lane16};
      3'b010:  ld_ext = rd_q;
      3'b100:  ld_ext = {24'b0, lane8};
      3'b101:  ld_ext = {16'b0, lane16};
      default: ld_ext = 32'b0;
    endcase
  end

  // Registered response; rdata holds until the next response.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_v     <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= 32'b0;
    end else if (state == S_RESP) begin
      rsp_v     <= 1'b1;
      rsp_err   <= p_err;
      rsp_rdata <= (p_err | p_we) ? 32'b0 : ld_ext;
    end else begin
      rsp_v   <= 1'b0;
      rsp_err <= 1'b0;
    end
  end
endmodule
